instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential program ROM reads and buffers the
// returned bytes, tagged with their addresses, in a first-word-fall-through
// prefetch FIFO for the decoder. A redirect flushes the FIFO and restarts
// fetching at a new address.
// Optional feature: define IFU_HALT_DETECT_EN to stop fetching after an 8'hFF
// (HLT) byte is pushed; a redirect resumes fetching.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic                     ins_valid,
  output logic [7:0]               ins_data,
  output logic [ADDR_W-1:0]        ins_pc,
  input  logic                     ins_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  localparam logic [LvlW:0]     DepthW  = (LvlW + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [LvlW-1:0]   r_level;
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [7:0]        r_fifo_data [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_halted;
  logic [LvlW:0]     w_occ;

`ifdef IFU_HALT_DETECT_EN
  logic r_halted;

  // Halt once an HLT byte enters the FIFO; only a redirect resumes fetching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_halted <= 1'b0;
    end else if (w_push && (mem_rdata == 8'hFF)) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  // Occupancy counts the byte already on its way back so the FIFO never overflows.
  always_comb begin
    w_occ     = {1'b0, r_level} + {{LvlW{1'b0}}, r_inflight};
    mem_req   = ~rst & ~redirect & ~w_halted & (w_occ < DepthW);
    // The response that follows an HLT push, or that arrives during a flush, is dropped.
    w_push    = r_inflight & ~w_halted & ~redirect;
    ins_valid = (r_level != '0);
    w_pop     = ins_valid & ins_ready;
    ins_data  = r_fifo_data[r_rptr];
    ins_pc    = r_fifo_pc[r_rptr];
    mem_addr  = r_fetch_pc;
    level     = r_level;
    halted    = w_halted;
  end

  // Fetch address and in-flight tracking for the one-cycle ROM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= ResetPc;
      r_inflight <= 1'b0;
      r_resp_pc  <= ResetPc;
    end else begin
      r_inflight <= mem_req;
      if (mem_req) begin
        r_resp_pc <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (mem_req) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect) begin
      r_level <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LvlW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LvlW'(1);
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= mem_rdata;
      r_fifo_pc[r_wptr]   <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (default parameters ADDR_W=8, DEPTH=4,
// RESET_PC=0). Table-driven vectors cover streaming, back-pressure, redirects and
// address wrap; hand-written sequences cover mid-operation reset and HLT handling.
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       ins_valid;
  logic [7:0] ins_data;
  logic [7:0] ins_pc;
  logic       ins_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [2:0] level;
  logic       halted;

  int n_cmp;
  int n_bad;

  logic [7:0] rom [256];

  typedef struct {
    logic       rdy;
    logic       rd;
    logic [7:0] rpc;
    logic       req;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] data;
    logic [7:0] pc;
    logic [2:0] lvl;
  } vec_t;

  vec_t vq[$];
  logic [7:0] got_pc[$];
  logic [7:0] got_data[$];

  instr_fetch_unit #(
    .ADDR_W  (8),
    .DEPTH   (4),
    .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .ins_valid  (ins_valid),
    .ins_data   (ins_data),
    .ins_pc     (ins_pc),
    .ins_ready  (ins_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .level      (level),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data for the address presented at an edge appears one cycle later.
  always @(posedge clk) mem_rdata <= rom[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Structural invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("level_bound", {31'd0, level <= 3'd4}, 32'd1);
      check("valid_vs_level", {31'd0, ins_valid}, {31'd0, level != 3'd0});
    end
  end

  task automatic add(input logic rdy, rd, input logic [7:0] rpc, input logic req,
                     input logic [7:0] addr, input logic vld, input logic [7:0] data,
                     input logic [7:0] pc, input logic [2:0] lvl);
    vq.push_back('{rdy, rd, rpc, req, addr, vld, data, pc, lvl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 16);

    // Streaming with the decoder always ready.
    add(1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h02, 1, 8'h10, 8'h00, 3'd1);
    add(1, 0, 8'h00, 1, 8'h03, 1, 8'h11, 8'h01, 3'd1);
    add(1, 0, 8'h00, 1, 8'h04, 1, 8'h12, 8'h02, 3'd1);
    // Back-pressure: FIFO fills to DEPTH, fetching stops, head held.
    add(0, 0, 8'h00, 1, 8'h05, 1, 8'h13, 8'h03, 3'd1);
    add(0, 0, 8'h00, 1, 8'h06, 1, 8'h13, 8'h03, 3'd2);
    add(0, 0, 8'h00, 0, 8'h07, 1, 8'h13, 8'h03, 3'd3);
    for (int i = 0; i < 7; i++) add(0, 0, 8'h00, 0, 8'h07, 1, 8'h13, 8'h03, 3'd4);
    // Release: bytes drain in order, fetch resumes at the next address.
    add(1, 0, 8'h00, 0, 8'h07, 1, 8'h13, 8'h03, 3'd4);
    add(1, 0, 8'h00, 1, 8'h07, 1, 8'h14, 8'h04, 3'd3);
    add(1, 0, 8'h00, 1, 8'h08, 1, 8'h15, 8'h05, 3'd2);
    add(1, 0, 8'h00, 1, 8'h09, 1, 8'h16, 8'h06, 3'd2);
    add(1, 0, 8'h00, 1, 8'h0A, 1, 8'h17, 8'h07, 3'd2);
    // Redirect to 80 with level 3 and a response in flight.
    add(0, 0, 8'h00, 1, 8'h0B, 1, 8'h18, 8'h08, 3'd2);
    add(0, 1, 8'h80, 0, 8'h0C, 1, 8'h18, 8'h08, 3'd3);
    add(1, 0, 8'h00, 1, 8'h80, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h81, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h82, 1, 8'h90, 8'h80, 3'd1);
    // Redirect coinciding with a pop, to FE; address wraps FF -> 00.
    add(1, 1, 8'hFE, 0, 8'h83, 1, 8'h91, 8'h81, 3'd1);
    add(1, 0, 8'h00, 1, 8'hFE, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'hFF, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h00, 1, 8'h0E, 8'hFE, 3'd1);
    add(1, 0, 8'h00, 1, 8'h01, 1, 8'h0F, 8'hFF, 3'd1);
    add(1, 0, 8'h00, 1, 8'h02, 1, 8'h10, 8'h00, 3'd1);
    add(1, 0, 8'h00, 1, 8'h03, 1, 8'h11, 8'h01, 3'd1);
    // Back-to-back redirects: the last one wins.
    add(1, 1, 8'h40, 0, 8'h04, 1, 8'h12, 8'h02, 3'd1);
    add(1, 1, 8'h50, 0, 8'h40, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h50, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h51, 0, 8'h00, 8'h00, 3'd0);
    add(1, 0, 8'h00, 1, 8'h52, 1, 8'h60, 8'h50, 3'd1);

    // Reset state.
    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    check("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    foreach (vq[k]) begin
      ins_ready   = vq[k].rdy;
      redirect    = vq[k].rd;
      redirect_pc = vq[k].rpc;
      #2;
      check($sformatf("v%0d_mem_req", k), {31'd0, mem_req}, {31'd0, vq[k].req});
      check($sformatf("v%0d_mem_addr", k), {24'd0, mem_addr}, {24'd0, vq[k].addr});
      check($sformatf("v%0d_ins_valid", k), {31'd0, ins_valid}, {31'd0, vq[k].vld});
      check($sformatf("v%0d_level", k), {29'd0, level}, {29'd0, vq[k].lvl});
      check($sformatf("v%0d_halted", k), {31'd0, halted}, 32'd0);
      if (vq[k].vld) begin
        check($sformatf("v%0d_ins_data", k), {24'd0, ins_data}, {24'd0, vq[k].data});
        check($sformatf("v%0d_ins_pc", k), {24'd0, ins_pc}, {24'd0, vq[k].pc});
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-operation: FIFO and in-flight response dropped at once.
    redirect = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    check("mid_rst_ins_valid", {31'd0, ins_valid}, 32'd0);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd0);

    // HLT byte at address 3; fetch from reset and collect delivered bytes.
    rom[3] = 8'hFF;
    tick();
    rst       = 1'b0;
    ins_ready = 1'b1;
    #2;
    check("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    check("post_rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (ins_valid) begin
        got_pc.push_back(ins_pc);
        got_data.push_back(ins_data);
      end
      @(posedge clk);
      #2;
    end
`ifdef IFU_HALT_DETECT_EN
    check("hlt_count", got_pc.size(), 32'd4);
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_mem_req", {31'd0, mem_req}, 32'd0);
    check("hlt_ins_valid", {31'd0, ins_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < got_pc.size()) begin
        check($sformatf("hlt_pc%0d", i), {24'd0, got_pc[i]}, i);
        check($sformatf("hlt_data%0d", i), {24'd0, got_data[i]},
              (i == 3) ? 32'hFF : 32'(i + 16));
      end
    end
`else
    check("nohlt_count", got_pc.size(), 32'd10);
    check("nohlt_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < got_pc.size()) begin
        check($sformatf("nohlt_pc%0d", i), {24'd0, got_pc[i]}, i);
        check($sformatf("nohlt_data%0d", i), {24'd0, got_data[i]},
              (i == 3) ? 32'hFF : 32'(i + 16));
      end
    end
`endif

    // Redirect to 0 clears halt and restarts fetching at 0.
    redirect    = 1'b1;
    redirect_pc = 8'h00;
    #1;
    check("redir_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    #1;
    check("redir_halted", {31'd0, halted}, 32'd0);
    check("redir_level", {29'd0, level}, 32'd0);
    check("redir_restart_req", {31'd0, mem_req}, 32'd1);
    check("redir_restart_addr", {24'd0, mem_addr}, 32'h00);
    tick();
    tick();
    check("redir_head_valid", {31'd0, ins_valid}, 32'd1);
    check("redir_head_pc", {24'd0, ins_pc}, 32'h00);
    check("redir_head_data", {24'd0, ins_data}, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
